// File: rtl/kf8259_in_service_sequencer.sv
// 8259 in-service sequencer: INTA acknowledge FSM, ISR, EOI and
// priority rotation feedback for the priority resolver.
module kf8259_in_service_sequencer #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7,
  parameter logic [2:0] RESET_ROTATE   = 3'b111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt,
  input  logic       ack_pulse,
  input  logic       ack_mode_8086,
  input  logic       auto_eoi_config,
  input  logic       ocw2_strobe,
  input  logic [2:0] ocw2_cmd,
  input  logic [2:0] ocw2_level,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [2:0] priority_rotate,
  output logic [1:0] ack_phase,
  output logic [2:0] latched_level,
  output logic [7:0] clear_request,
  output logic       end_of_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2,
    ACK3 = 2'd3
  } state_t;

  state_t     state, state_n;
  logic       auto_rotate, auto_rotate_n;
  logic       spurious, spurious_n;
  logic [7:0] isr_n;
  logic [2:0] rotate_n;
  logic [2:0] level_n;
  logic [7:0] clr_req_n;
  logic       eoa_n;
  logic       hl_found;
  logic [2:0] hl_idx;
  logic [2:0] hl_lvl;
  logic [2:0] intr_idx;
  logic [7:0] set_bits;
  logic [7:0] aeoi_clr;
  logic [7:0] ocw_clr;

  assign ack_phase = state;

  // Highest-priority ISR bit, scanning from level rotate+1 upward.
  always_comb begin
    hl_found = 1'b0;
    hl_idx   = 3'd0;
    hl_lvl   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      hl_lvl = priority_rotate + 3'd1 + k[2:0];
      if (!hl_found && in_service_register[hl_lvl]) begin
        hl_found = 1'b1;
        hl_idx   = hl_lvl;
      end
    end
    highest_level_in_service =
      hl_found ? (8'd1 << hl_idx) : 8'd0;
  end

  // Index of the resolver winner.
  always_comb begin
    intr_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (interrupt[i]) intr_idx = 3'(i);
    end
  end

  // Acknowledge FSM, AEOI and OCW2 next-state logic.
  always_comb begin
    state_n       = state;
    level_n       = latched_level;
    spurious_n    = spurious;
    clr_req_n     = 8'd0;
    eoa_n         = 1'b0;
    set_bits      = 8'd0;
    aeoi_clr      = 8'd0;
    ocw_clr       = 8'd0;
    rotate_n      = priority_rotate;
    auto_rotate_n = auto_rotate;

    unique case (state)
      IDLE, ACK1: begin
        if (ack_pulse) begin
          state_n = ACK2;
          if (interrupt != 8'd0) begin
            level_n    = intr_idx;
            set_bits   = 8'd1 << intr_idx;
            clr_req_n  = interrupt;
            spurious_n = 1'b0;
          end else begin
            level_n    = SPURIOUS_LEVEL;
            spurious_n = 1'b1;
          end
        end
      end
      ACK2: begin
        if (ack_pulse) begin
          if (ack_mode_8086) begin
            state_n = IDLE;
            eoa_n   = 1'b1;
          end else begin
            state_n = ACK3;
          end
        end
      end
      ACK3: begin
        if (ack_pulse) begin
          state_n = IDLE;
          eoa_n   = 1'b1;
        end
      end
    endcase

    if (eoa_n && auto_eoi_config && !spurious) begin
      aeoi_clr = 8'd1 << latched_level;
      if (auto_rotate) rotate_n = latched_level;
    end

    if (ocw2_strobe) begin
      unique case (ocw2_cmd)
        3'b001: ocw_clr = highest_level_in_service;
        3'b011: ocw_clr = 8'd1 << ocw2_level;
        3'b101: begin
          if (hl_found) begin
            ocw_clr  = highest_level_in_service;
            rotate_n = hl_idx;
          end
        end
        3'b111: begin
          ocw_clr  = 8'd1 << ocw2_level;
          rotate_n = ocw2_level;
        end
        3'b110: rotate_n = ocw2_level;
        3'b100: auto_rotate_n = 1'b1;
        3'b000: auto_rotate_n = 1'b0;
        3'b010: ;
      endcase
    end

    isr_n = (in_service_register & ~(ocw_clr | aeoi_clr))
          | set_bits;
  end

  // Register all state and pulse outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      in_service_register <= 8'd0;
      priority_rotate     <= RESET_ROTATE;
      latched_level       <= 3'd0;
      clear_request       <= 8'd0;
      end_of_ack          <= 1'b0;
      auto_rotate         <= 1'b0;
      spurious            <= 1'b0;
    end else begin
      state               <= state_n;
      in_service_register <= isr_n;
      priority_rotate     <= rotate_n;
      latched_level       <= level_n;
      clear_request       <= clr_req_n;
      end_of_ack          <= eoa_n;
      auto_rotate         <= auto_rotate_n;
      spurious            <= spurious_n;
    end
  end

endmodule

// File: tb/tb_kf8259_in_service_sequencer.sv
// Bench for kf8259_in_service_sequencer: directed scenarios plus
// random traffic against an arithmetic reference model.
module tb_kf8259_in_service_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] interrupt;
  logic       ack_pulse;
  logic       ack_mode_8086;
  logic       auto_eoi_config;
  logic       ocw2_strobe;
  logic [2:0] ocw2_cmd;
  logic [2:0] ocw2_level;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic [2:0] priority_rotate;
  logic [1:0] ack_phase;
  logic [2:0] latched_level;
  logic [7:0] clear_request;
  logic       end_of_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  kf8259_in_service_sequencer dut (
    .clock                    (clock),
    .reset                    (reset),
    .interrupt                (interrupt),
    .ack_pulse                (ack_pulse),
    .ack_mode_8086            (ack_mode_8086),
    .auto_eoi_config          (auto_eoi_config),
    .ocw2_strobe              (ocw2_strobe),
    .ocw2_cmd                 (ocw2_cmd),
    .ocw2_level               (ocw2_level),
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service),
    .priority_rotate          (priority_rotate),
    .ack_phase                (ack_phase),
    .latched_level            (latched_level),
    .clear_request            (clear_request),
    .end_of_ack               (end_of_ack)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    interrupt       = 8'd0;
    ack_pulse       = 1'b0;
    ack_mode_8086   = 1'b1;
    auto_eoi_config = 1'b0;
    ocw2_strobe     = 1'b0;
    ocw2_cmd        = 3'd0;
    ocw2_level      = 3'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic ack();
    ack_pulse = 1'b1;
    tick();
    ack_pulse = 1'b0;
  endtask

  task automatic ocw2(input logic [2:0] c, input logic [2:0] l);
    ocw2_strobe = 1'b1;
    ocw2_cmd    = c;
    ocw2_level  = l;
    tick();
    ocw2_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (in_service_register !== 8'd0 || priority_rotate !== 3'b111
        || ack_phase !== 2'd0 || latched_level !== 3'd0
        || clear_request !== 8'd0 || end_of_ack !== 1'b0
        || highest_level_in_service !== 8'd0) begin
      n_bad++;
      $display("FAIL reset: isr=%h rot=%0d ph=%0d lat=%0d cr=%h eoa=%b",
               in_service_register, priority_rotate, ack_phase,
               latched_level, clear_request, end_of_ack);
    end
    do_reset();
  endtask

  task automatic test_8086();
    do_reset();
    ack_mode_8086 = 1'b1;
    interrupt = 8'h08;
    ack();
    n_cmp++;
    if (ack_phase !== 2'd2 || in_service_register !== 8'h08
        || clear_request !== 8'h08 || latched_level !== 3'd3
        || end_of_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_first: ph=%0d isr=%h cr=%h lat=%0d eoa=%b want 2 08 08 3 0",
               ack_phase, in_service_register, clear_request,
               latched_level, end_of_ack);
    end
    tick();
    n_cmp++;
    if (clear_request !== 8'd0 || ack_phase !== 2'd2) begin
      n_bad++;
      $display("FAIL t1_hold: cr=%h ph=%0d want 00 2",
               clear_request, ack_phase);
    end
    ack();
    n_cmp++;
    if (ack_phase !== 2'd0 || end_of_ack !== 1'b1
        || in_service_register !== 8'h08) begin
      n_bad++;
      $display("FAIL t1_end: ph=%0d eoa=%b isr=%h want 0 1 08",
               ack_phase, end_of_ack, in_service_register);
    end
    tick();
    n_cmp++;
    if (end_of_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_eoa_pulse: eoa=%b want 0", end_of_ack);
    end
  endtask

  task automatic test_8080();
    do_reset();
    ack_mode_8086 = 1'b0;
    interrupt = 8'h01;
    ack();
    n_cmp++;
    if (ack_phase !== 2'd2 || end_of_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL t2_p1: ph=%0d eoa=%b want 2 0", ack_phase, end_of_ack);
    end
    ack();
    n_cmp++;
    if (ack_phase !== 2'd3 || end_of_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL t2_p2: ph=%0d eoa=%b want 3 0", ack_phase, end_of_ack);
    end
    ack();
    n_cmp++;
    if (ack_phase !== 2'd0 || end_of_ack !== 1'b1
        || in_service_register !== 8'h01) begin
      n_bad++;
      $display("FAIL t2_p3: ph=%0d eoa=%b isr=%h want 0 1 01",
               ack_phase, end_of_ack, in_service_register);
    end
  endtask

  task automatic test_aeoi_rotate();
    do_reset();
    auto_eoi_config = 1'b1;
    ocw2(3'b100, 3'd0);
    interrupt = 8'h20;
    ack();
    n_cmp++;
    if (in_service_register !== 8'h20) begin
      n_bad++;
      $display("FAIL t3_set: isr=%h want 20", in_service_register);
    end
    ack();
    n_cmp++;
    if (in_service_register !== 8'h00 || priority_rotate !== 3'd5
        || end_of_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL t3_aeoi: isr=%h rot=%0d eoa=%b want 00 5 1",
               in_service_register, priority_rotate, end_of_ack);
    end
    auto_eoi_config = 1'b0;
  endtask

  task automatic test_ocw2_eoi();
    do_reset();
    interrupt = 8'h02;
    ack();
    ack();
    interrupt = 8'h80;
    ack();
    ack();
    n_cmp++;
    if (in_service_register !== 8'h82
        || highest_level_in_service !== 8'h02) begin
      n_bad++;
      $display("FAIL t4_pre: isr=%h hl=%h want 82 02",
               in_service_register, highest_level_in_service);
    end
    ocw2(3'b001, 3'd0);
    n_cmp++;
    if (in_service_register !== 8'h80) begin
      n_bad++;
      $display("FAIL t4_nseoi: isr=%h want 80", in_service_register);
    end
    ocw2(3'b110, 3'd1);
    n_cmp++;
    if (priority_rotate !== 3'd1 || in_service_register !== 8'h80) begin
      n_bad++;
      $display("FAIL t4_setpri: rot=%0d isr=%h want 1 80",
               priority_rotate, in_service_register);
    end
    ocw2(3'b101, 3'd0);
    n_cmp++;
    if (in_service_register !== 8'h00 || priority_rotate !== 3'd7) begin
      n_bad++;
      $display("FAIL t4_rot_nseoi: isr=%h rot=%0d want 00 7",
               in_service_register, priority_rotate);
    end
    ocw2(3'b101, 3'd2);
    n_cmp++;
    if (in_service_register !== 8'h00 || priority_rotate !== 3'd7) begin
      n_bad++;
      $display("FAIL t4_rot_empty: isr=%h rot=%0d want 00 7",
               in_service_register, priority_rotate);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    interrupt = 8'h80;
    ack();
    ack();
    auto_eoi_config = 1'b1;
    interrupt = 8'h00;
    ack();
    n_cmp++;
    if (latched_level !== 3'd7 || clear_request !== 8'd0
        || in_service_register !== 8'h80 || ack_phase !== 2'd2) begin
      n_bad++;
      $display("FAIL t5_first: lat=%0d cr=%h isr=%h ph=%0d want 7 00 80 2",
               latched_level, clear_request, in_service_register,
               ack_phase);
    end
    ack();
    n_cmp++;
    if (end_of_ack !== 1'b1 || ack_phase !== 2'd0
        || in_service_register !== 8'h80) begin
      n_bad++;
      $display("FAIL t5_end: eoa=%b ph=%0d isr=%h want 1 0 80",
               end_of_ack, ack_phase, in_service_register);
    end
    auto_eoi_config = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    interrupt = 8'h08;
    ack();
    ocw2(3'b110, 3'd2);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (ack_phase !== 2'd0 || in_service_register !== 8'd0
        || priority_rotate !== 3'b111 || end_of_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL t6_reset_mid: ph=%0d isr=%h rot=%0d eoa=%b want 0 00 7 0",
               ack_phase, in_service_register, priority_rotate, end_of_ack);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    interrupt = 8'h08;
    ack_pulse = 1'b1;
    ocw2(3'b011, 3'd3);
    ack_pulse = 1'b0;
    n_cmp++;
    if (in_service_register !== 8'h08) begin
      n_bad++;
      $display("FAIL sim_set_wins: isr=%h want 08", in_service_register);
    end
    auto_eoi_config = 1'b1;
    ocw2(3'b100, 3'd0);
    ack_pulse = 1'b1;
    ocw2(3'b110, 3'd6);
    ack_pulse = 1'b0;
    n_cmp++;
    if (priority_rotate !== 3'd6 || in_service_register !== 8'h00) begin
      n_bad++;
      $display("FAIL sim_ocw_rot_wins: rot=%0d isr=%h want 6 00",
               priority_rotate, in_service_register);
    end
    auto_eoi_config = 1'b0;
  endtask

  // Reference model state.
  bit [7:0] m_isr;
  int       m_rot;
  bit       m_auto;
  int       m_phase;
  int       m_lat;
  bit       m_spur;
  bit [7:0] m_creq;
  bit       m_eoa;

  function automatic int top_level(bit [7:0] isr, int rot);
    for (int p = 1; p <= 8; p++) begin
      if (isr[(rot + p) % 8]) return (rot + p) % 8;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit [7:0] set_b = 8'd0;
    bit [7:0] clr_b = 8'd0;
    int nrot = m_rot;
    int top  = top_level(m_isr, m_rot);
    bit eoa  = 1'b0;
    m_creq = 8'd0;
    if (ack_pulse) begin
      if (m_phase == 0 || m_phase == 1) begin
        m_phase = 2;
        if (interrupt != 8'd0) begin
          for (int i = 0; i < 8; i++)
            if (interrupt[i]) m_lat = i;
          set_b  = interrupt;
          m_creq = interrupt;
          m_spur = 1'b0;
        end else begin
          m_lat  = 7;
          m_spur = 1'b1;
        end
      end else if (m_phase == 2) begin
        if (ack_mode_8086) begin
          m_phase = 0;
          eoa = 1'b1;
        end else m_phase = 3;
      end else begin
        m_phase = 0;
        eoa = 1'b1;
      end
    end
    if (eoa && auto_eoi_config && !m_spur) begin
      clr_b[m_lat] = 1'b1;
      if (m_auto) nrot = m_lat;
    end
    if (ocw2_strobe) begin
      case (ocw2_cmd)
        3'b001: if (top >= 0) clr_b[top] = 1'b1;
        3'b011: clr_b[ocw2_level] = 1'b1;
        3'b101: if (top >= 0) begin
          clr_b[top] = 1'b1;
          nrot = top;
        end
        3'b111: begin
          clr_b[ocw2_level] = 1'b1;
          nrot = ocw2_level;
        end
        3'b110: nrot = ocw2_level;
        3'b100: m_auto = 1'b1;
        3'b000: m_auto = 1'b0;
        default: ;
      endcase
    end
    m_isr = (m_isr & ~clr_b) | set_b;
    m_rot = nrot;
    m_eoa = eoa;
  endtask

  task automatic test_random();
    int top;
    bit [7:0] exp_hl;
    do_reset();
    m_isr = 0; m_rot = 7; m_auto = 0; m_phase = 0;
    m_lat = 0; m_spur = 0; m_creq = 0; m_eoa = 0;
    for (int c = 0; c < 400; c++) begin
      interrupt = ($urandom_range(0, 3) == 0) ? 8'd0
                : (8'd1 << $urandom_range(0, 7));
      ack_pulse       = ($urandom_range(0, 2) == 0);
      ack_mode_8086   = 1'($urandom_range(0, 1));
      auto_eoi_config = ($urandom_range(0, 3) != 0);
      ocw2_strobe     = ($urandom_range(0, 3) == 0);
      ocw2_cmd        = 3'($urandom_range(0, 7));
      ocw2_level      = 3'($urandom_range(0, 7));
      model_step();
      tick();
      top = top_level(m_isr, m_rot);
      exp_hl = (top >= 0) ? (8'd1 << top) : 8'd0;
      n_cmp++;
      if (in_service_register !== m_isr) begin
        n_bad++;
        $display("FAIL rnd_isr c=%0d: got %h want %h",
                 c, in_service_register, m_isr);
      end
      n_cmp++;
      if (priority_rotate !== 3'(m_rot)) begin
        n_bad++;
        $display("FAIL rnd_rot c=%0d: got %0d want %0d",
                 c, priority_rotate, m_rot);
      end
      n_cmp++;
      if (ack_phase !== 2'(m_phase) || end_of_ack !== m_eoa) begin
        n_bad++;
        $display("FAIL rnd_phase c=%0d: got %0d/%b want %0d/%b",
                 c, ack_phase, end_of_ack, m_phase, m_eoa);
      end
      n_cmp++;
      if (latched_level !== 3'(m_lat) || clear_request !== m_creq) begin
        n_bad++;
        $display("FAIL rnd_lat c=%0d: got %0d/%h want %0d/%h",
                 c, latched_level, clear_request, m_lat, m_creq);
      end
      n_cmp++;
      if (highest_level_in_service !== exp_hl) begin
        n_bad++;
        $display("FAIL rnd_hl c=%0d: got %h want %h",
                 c, highest_level_in_service, exp_hl);
      end
    end
    ack_pulse   = 1'b0;
    ocw2_strobe = 1'b0;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_8086();
    test_8080();
    test_aeoi_rotate();
    test_ocw2_eoi();
    test_spurious();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
